spi_reg_responder: RTL and testbench



---
 rtl/spi_reg_responder.sv | 201 ++++++++++++++++++++
 tb/tb_spi_reg_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder: oversamples the HPS SPI pins in the clk domain and turns
// each frame (R/W, address, data) into a one-cycle register write or read strobe.
module spi_reg_responder #(
    parameter int unsigned ADDR_WIDTH  = 7,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  spi_sclk,
    input  logic                  spi_ss_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe_n,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_wr_en,
    output logic                  reg_rd_en,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int unsigned FRAME_LEN = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned CMD_LEN   = 1 + ADDR_WIDTH;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int unsigned SH_W      = (CMD_LEN > DATA_WIDTH) ? CMD_LEN : DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_ss_d;
    logic                   r_ss_seen_high;
    logic                   r_miso_oe_n;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [SH_W-2:0]        r_shift;
    logic                   r_rw;
    logic                   r_rd_req;
    logic                   r_tx_load;
    logic [DATA_WIDTH-1:0]  r_tx;
    logic                   r_miso;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic                   r_wr_en;
    logic                   r_rd_en;
    logic                   r_frame_err;
    logic                   r_busy;

    logic                   w_sclk_s;
    logic                   w_ss_s;
    logic                   w_mosi_s;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_ss_fall;
    logic                   w_ss_rise;
    logic [SH_W-1:0]        w_shift_next;

    assign w_sclk_s     = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_s       = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s     = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise  = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall  = ~w_sclk_s & r_sclk_d;
    assign w_ss_fall    = ~w_ss_s & r_ss_d;
    assign w_ss_rise    = w_ss_s & ~r_ss_d;
    assign w_shift_next = {r_shift, w_mosi_s};

    // Pin synchronizers and edge history. ss_n restarts low after reset so a frame
    // already in flight is never mistaken for a new start; the responder waits for
    // a real high level, and keeps MISO disabled until it has seen one.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sclk_sync    <= '0;
            r_ss_sync      <= '0;
            r_mosi_sync    <= '0;
            r_sclk_d       <= 1'b0;
            r_ss_d         <= 1'b0;
            r_ss_seen_high <= 1'b0;
            r_miso_oe_n    <= 1'b1;
        end else begin
            r_sclk_sync    <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_ss_sync      <= {r_ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            r_mosi_sync    <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sclk_d       <= w_sclk_s;
            r_ss_d         <= w_ss_s;
            r_ss_seen_high <= r_ss_seen_high | w_ss_s;
            r_miso_oe_n    <= r_ss_sync[SYNC_STAGES-2] | ~(r_ss_seen_high | w_ss_s);
        end
    end

    // Frame FSM: bit counting, address/data capture, strobes and MISO shifting.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rw        <= 1'b0;
            r_rd_req    <= 1'b0;
            r_tx_load   <= 1'b0;
            r_tx        <= '0;
            r_miso      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_wr_en     <= 1'b0;
            r_frame_err <= 1'b0;
            r_rd_en     <= r_rd_req;
            r_rd_req    <= 1'b0;
            r_tx_load   <= r_rd_en;
            if (r_tx_load) begin
                r_tx <= reg_rdata;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_ss_fall) begin
                        r_state   <= ST_CMD;
                        r_busy    <= 1'b1;
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                        r_tx      <= '0;
                        r_rw      <= 1'b0;
                        r_miso    <= 1'b0;
                    end
                end
                ST_CMD: begin
                    if (w_ss_rise) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_frame_err <= 1'b1;
                        r_miso      <= 1'b0;
                    end else if (w_sclk_rise) begin
                        r_shift   <= w_shift_next[SH_W-2:0];
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        if (r_bit_cnt == CNT_W'(ADDR_WIDTH)) begin
                            r_state  <= ST_DATA;
                            r_rw     <= w_shift_next[ADDR_WIDTH];
                            r_rd_req <= w_shift_next[ADDR_WIDTH];
                            r_addr   <= w_shift_next[ADDR_WIDTH-1:0];
                        end
                    end
                end
                ST_DATA: begin
                    // ss_n release beats a coincident final SCLK edge.
                    if (w_ss_rise) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_frame_err <= 1'b1;
                        r_miso      <= 1'b0;
                    end else if (w_sclk_rise) begin
                        r_shift   <= w_shift_next[SH_W-2:0];
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        if (r_bit_cnt == CNT_W'(FRAME_LEN - 1)) begin
                            r_state <= ST_DONE;
                            r_miso  <= 1'b0;
                            if (!r_rw) begin
                                r_wdata <= w_shift_next[DATA_WIDTH-1:0];
                                r_wr_en <= 1'b1;
                            end
                        end
                    end else if (w_sclk_fall && r_rw) begin
                        r_miso <= r_tx[DATA_WIDTH-1];
                        r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                ST_DONE: begin
                    if (w_ss_rise) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign spi_miso      = r_miso;
    assign spi_miso_oe_n = r_miso_oe_n;
    assign reg_addr      = r_addr;
    assign reg_wdata     = r_wdata;
    assign reg_wr_en     = r_wr_en;
    assign reg_rd_en     = r_rd_en;
    assign frame_err     = r_frame_err;
    assign busy          = r_busy;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench for spi_reg_responder: bit-bangs SPI frames and checks strobes,
// latencies, MISO read-back, aborts and mid-frame reset.
`timescale 1ns/1ps
module tb_spi_reg_responder;

    localparam int HALF = 8;  // clk cycles per SCLK half period

    logic       clk = 1'b0;
    logic       reset_n;
    logic       spi_sclk;
    logic       spi_ss_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe_n;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [7:0] reg_rdata;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         err_cnt = 0;
    logic [6:0] wr_addr [32];
    logic [7:0] wr_data [32];
    int         wr_cyc  [32];
    logic [6:0] rd_addr [32];
    int         rd_cyc  [32];

    logic [7:0]  rd_value = 8'h00;
    logic [31:0] miso_vec;
    int          rise_cmd_cyc;
    int          rise_last_cyc;
    logic        busy_mid;
    logic [31:0] snap;

    spi_reg_responder dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .spi_sclk      (spi_sclk),
        .spi_ss_n      (spi_ss_n),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .spi_miso_oe_n (spi_miso_oe_n),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_wr_en     (reg_wr_en),
        .reg_rd_en     (reg_rd_en),
        .reg_rdata     (reg_rdata),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register-file read port: data valid one clk after the read strobe.
    always @(posedge clk) reg_rdata <= reg_rd_en ? rd_value : 8'hA5;

    // Strobe recorder, sampled away from the active edge.
    always @(negedge clk) begin
        if (reg_wr_en) begin
            if (wr_cnt < 32) begin
                wr_addr[wr_cnt] <= reg_addr;
                wr_data[wr_cnt] <= reg_wdata;
                wr_cyc[wr_cnt]  <= cyc;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (reg_rd_en) begin
            if (rd_cnt < 32) begin
                rd_addr[rd_cnt] <= reg_addr;
                rd_cyc[rd_cnt]  <= cyc;
            end
            rd_cnt <= rd_cnt + 1;
        end
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] frame(input logic rw, input logic [6:0] a, input logic [7:0] d);
        return {16'h0, rw, a, d};
    endfunction

    // Master side of one frame: n bits MSB of word first; optional reset pulse
    // before bit rst_at, optional ss_n release together with the last rising edge.
    task automatic spi_xfer(input logic [31:0] word, input int n, input int rst_at, input bit ss_with_last);
        miso_vec = '0;
        @(negedge clk);
        spi_ss_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) begin
                reset_n = 1'b0;
                @(negedge clk);
                snap = {22'h0, spi_miso, spi_miso_oe_n, reg_wr_en, reg_rd_en, frame_err, busy,
                        (reg_addr == 7'h0), (reg_wdata == 8'h0), 2'b00};
                reset_n = 1'b1;
            end
            spi_mosi = word[n-1-i];
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b1;
            miso_vec[i] = spi_miso;
            if (i == 7) rise_cmd_cyc = cyc;
            if (i == n - 1) begin
                rise_last_cyc = cyc;
                busy_mid = busy;
                if (ss_with_last) spi_ss_n = 1'b1;
            end
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        spi_ss_n = 1'b1;
        repeat (4 * HALF) @(negedge clk);
    endtask

    initial begin
        int          wr0, rd0, er0;
        logic [31:0] w;
        logic [31:0] exp_miso;

        reset_n  = 1'b0;
        spi_sclk = 1'b0;
        spi_ss_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clk);

        // Reset state
        chk("rst_miso", 32'(spi_miso), 32'd0);
        chk("rst_oe_n", 32'(spi_miso_oe_n), 32'd1);
        chk("rst_addr", 32'(reg_addr), 32'd0);
        chk("rst_wdata", 32'(reg_wdata), 32'd0);
        chk("rst_strobes", {29'h0, reg_wr_en, reg_rd_en, frame_err}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("idle_oe_n", 32'(spi_miso_oe_n), 32'd1);

        // Plain write 0x05 <- 0x2A
        wr0 = wr_cnt; rd0 = rd_cnt; er0 = err_cnt;
        spi_xfer(frame(1'b0, 7'h05, 8'h2A), 16, -1, 1'b0);
        chk("w1_count", 32'(wr_cnt - wr0), 32'd1);
        chk("w1_addr", 32'(wr_addr[wr0]), 32'h05);
        chk("w1_data", 32'(wr_data[wr0]), 32'h2A);
        chk("w1_latency", 32'(wr_cyc[wr0] - rise_last_cyc), 32'd3);
        chk("w1_busy_mid", 32'(busy_mid), 32'd1);
        chk("w1_busy_end", 32'(busy), 32'd0);
        chk("w1_no_rd", 32'(rd_cnt - rd0), 32'd0);
        chk("w1_no_err", 32'(err_cnt - er0), 32'd0);
        chk("w1_miso", miso_vec, 32'd0);

        // Reads 0x11 -> 0xC3 and 0x2A -> 0x96
        for (int k = 0; k < 2; k++) begin
            logic [6:0] a;
            a = (k == 0) ? 7'h11 : 7'h2A;
            rd_value = (k == 0) ? 8'hC3 : 8'h96;
            exp_miso = '0;
            for (int j = 0; j < 8; j++) exp_miso[8+j] = rd_value[7-j];
            wr0 = wr_cnt; rd0 = rd_cnt; er0 = err_cnt;
            spi_xfer(frame(1'b1, a, 8'h00), 16, -1, 1'b0);
            chk("rd_count", 32'(rd_cnt - rd0), 32'd1);
            chk("rd_addr", 32'(rd_addr[rd0]), 32'(a));
            chk("rd_latency", 32'(rd_cyc[rd0] - rise_cmd_cyc), 32'd4);
            chk("rd_miso_bits", miso_vec, exp_miso);
            chk("rd_no_wr", 32'(wr_cnt - wr0), 32'd0);
            chk("rd_no_err", 32'(err_cnt - er0), 32'd0);
        end

        // Abort after 10 bits, then a good write 0x01 <- 0x7F
        wr0 = wr_cnt; er0 = err_cnt;
        w = frame(1'b0, 7'h01, 8'hFF) >> 6;
        spi_xfer(w, 10, -1, 1'b0);
        chk("abort_err", 32'(err_cnt - er0), 32'd1);
        chk("abort_no_wr", 32'(wr_cnt - wr0), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        wr0 = wr_cnt;
        spi_xfer(frame(1'b0, 7'h01, 8'h7F), 16, -1, 1'b0);
        chk("post_abort_count", 32'(wr_cnt - wr0), 32'd1);
        chk("post_abort_pair", {wr_addr[wr0], wr_data[wr0]}, {7'h01, 8'h7F});

        // Back-to-back frames
        wr0 = wr_cnt; er0 = err_cnt;
        spi_xfer(frame(1'b0, 7'h02, 8'h11), 16, -1, 1'b0);
        spi_xfer(frame(1'b0, 7'h03, 8'h22), 16, -1, 1'b0);
        chk("b2b_count", 32'(wr_cnt - wr0), 32'd2);
        chk("b2b_first", {wr_addr[wr0], wr_data[wr0]}, {7'h02, 8'h11});
        chk("b2b_second", {wr_addr[wr0+1], wr_data[wr0+1]}, {7'h03, 8'h22});
        chk("b2b_no_err", 32'(err_cnt - er0), 32'd0);

        // 20-bit burst: trailing edges ignored
        wr0 = wr_cnt; er0 = err_cnt;
        w = (frame(1'b0, 7'h04, 8'h55) << 4) | 32'hF;
        spi_xfer(w, 20, -1, 1'b0);
        chk("burst_count", 32'(wr_cnt - wr0), 32'd1);
        chk("burst_pair", {wr_addr[wr0], wr_data[wr0]}, {7'h04, 8'h55});
        chk("burst_miso", miso_vec, 32'd0);
        chk("burst_no_err", 32'(err_cnt - er0), 32'd0);

        // ss_n release coincident with the 16th rising edge
        wr0 = wr_cnt; er0 = err_cnt;
        spi_xfer(frame(1'b0, 7'h08, 8'h99), 16, -1, 1'b1);
        chk("race_err", 32'(err_cnt - er0), 32'd1);
        chk("race_no_wr", 32'(wr_cnt - wr0), 32'd0);

        // Reset pulse before bit 12 of a write, then a normal write
        wr0 = wr_cnt; rd0 = rd_cnt; er0 = err_cnt;
        spi_xfer(frame(1'b0, 7'h06, 8'h33), 16, 11, 1'b0);
        // snap: miso, oe_n, wr, rd, err, busy, addr==0, wdata==0, 2'b00
        chk("mid_rst_outputs", snap, 32'b01_0000_1100);
        chk("mid_rst_no_wr", 32'(wr_cnt - wr0), 32'd0);
        chk("mid_rst_no_rd", 32'(rd_cnt - rd0), 32'd0);
        chk("mid_rst_no_err", 32'(err_cnt - er0), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        wr0 = wr_cnt;
        spi_xfer(frame(1'b0, 7'h07, 8'h44), 16, -1, 1'b0);
        chk("post_rst_count", 32'(wr_cnt - wr0), 32'd1);
        chk("post_rst_pair", {wr_addr[wr0], wr_data[wr0]}, {7'h07, 8'h44});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
